// File: rtl/snapjack_input_pkg.sv
// Shared definitions for the Snap Jack input conditioning stage: PS/2 scancodes,
// MiSTer joystick bit positions, key-latch indices and the coin pulser states.
package snapjack_input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Joystick bit map, identical for both pads
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE  = 4;
  localparam int JOY_BOMB  = 5;
  localparam int JOY_COIN  = 6;
  localparam int JOY_START = 7;

  // P1 cursor keys match with or without the extended prefix, so only the low byte is compared
  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;

  // All remaining keys are full 9-bit codes (extended flag must be clear)
  localparam logic [8:0] SC_P1_FIRE    = 9'h014;
  localparam logic [8:0] SC_P1_BOMB    = 9'h029;
  localparam logic [8:0] SC_P1_START_A = 9'h005;
  localparam logic [8:0] SC_P1_START_B = 9'h016;
  localparam logic [8:0] SC_P2_UP      = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN    = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT    = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT   = 9'h034;
  localparam logic [8:0] SC_P2_FIRE    = 9'h01C;
  localparam logic [8:0] SC_P2_BOMB    = 9'h01B;
  localparam logic [8:0] SC_P2_START_A = 9'h006;
  localparam logic [8:0] SC_P2_START_B = 9'h01E;
  localparam logic [8:0] SC_COIN0      = 9'h02E;
  localparam logic [8:0] SC_COIN1      = 9'h036;

  // Positions of each function in the key latch vector
  localparam int NUM_KEYS = 16;
  localparam logic [3:0] KEY_P1_UP    = 4'd0;
  localparam logic [3:0] KEY_P1_DOWN  = 4'd1;
  localparam logic [3:0] KEY_P1_LEFT  = 4'd2;
  localparam logic [3:0] KEY_P1_RIGHT = 4'd3;
  localparam logic [3:0] KEY_P1_FIRE  = 4'd4;
  localparam logic [3:0] KEY_P1_BOMB  = 4'd5;
  localparam logic [3:0] KEY_P1_START = 4'd6;
  localparam logic [3:0] KEY_P2_UP    = 4'd7;
  localparam logic [3:0] KEY_P2_DOWN  = 4'd8;
  localparam logic [3:0] KEY_P2_LEFT  = 4'd9;
  localparam logic [3:0] KEY_P2_RIGHT = 4'd10;
  localparam logic [3:0] KEY_P2_FIRE  = 4'd11;
  localparam logic [3:0] KEY_P2_BOMB  = 4'd12;
  localparam logic [3:0] KEY_P2_START = 4'd13;
  localparam logic [3:0] KEY_COIN0    = 4'd14;
  localparam logic [3:0] KEY_COIN1    = 4'd15;

endpackage

// File: rtl/snapjack_coin_pulser.sv
// One coin slot: turns rising edges of a request level into fixed-width, spaced
// active-low coin pulses, buffering up to three credits.
module snapjack_coin_pulser
  import snapjack_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 400000,
  parameter int COIN_GAP_CYC   = 400000,
  parameter int CNT_W          = 20
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic req,
  output logic coin_n,
  output logic busy
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  coin_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       credits_q, credits_d;
  logic             reqPrev_q;
  logic             coinN_q;
  logic             reqEdge;
  logic             takeCredit;

  // Next-state logic: pulse/gap timing plus credit bookkeeping (a simultaneous take and new edge cancel out)
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    credits_d  = credits_q;
    takeCredit = 1'b0;
    reqEdge    = req & ~reqPrev_q;

    case (state_q)
      IDLE: begin
        if (credits_q != 2'd0) begin
          takeCredit = 1'b1;
          cnt_d      = PULSE_LOAD;
          state_d    = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (takeCredit && !reqEdge) begin
      credits_d = credits_q - 2'd1;
    end else if (!takeCredit && reqEdge && credits_q != 2'd3) begin
      credits_d = credits_q + 2'd1;
    end
  end

  // State, counter, credits and the registered coin line; reset aborts any pulse at once
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      credits_q <= 2'd0;
      reqPrev_q <= 1'b0;
      coinN_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      reqPrev_q <= req;
      coinN_q   <= (state_q != PULSE);
    end
  end

  assign coin_n = coinN_q;
  assign busy   = (state_q != IDLE) || (credits_q != 2'd0);

endmodule

// File: rtl/snapjack_input_ctrl.sv
// Snap Jack input conditioning: PS/2 key latches merged with two MiSTer pads,
// opposing-direction masking, coin pulse generation and registered active-low buses.
module snapjack_input_ctrl
  import snapjack_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 400000,
  parameter int COIN_GAP_CYC   = 400000,
  parameter int CNT_W          = 20
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [1:0]  but_coin_s,
  output logic [1:0]  but_select_s,
  output logic [1:0]  but_fire_s,
  output logic [1:0]  but_bomb_s,
  output logic [1:0]  but_up_s,
  output logic [1:0]  but_down_s,
  output logic [1:0]  but_left_s,
  output logic [1:0]  but_right_s,
  output logic [1:0]  coin_busy
);

  logic                primed_q;
  logic                prevTog_q;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [8:0]          code;
  logic                keyHit;
  logic [3:0]          keyIdx;
  logic [1:0]          up, down, left, right, fire, bomb, start;
  logic [1:0]          coinReq;
  logic [1:0]          butUp_q, butDown_q, butLeft_q, butRight_q;
  logic [1:0]          butFire_q, butBomb_q, butSelect_q;
  logic                unusedJoyBits;

  assign code          = ps2_key[8:0];
  assign unusedJoyBits = ^{joystick_0[15:8], joystick_1[15:8]};

  // Scancode lookup; cursor keys ignore the extended flag, everything else needs it clear
  always_comb begin
    keyHit = 1'b1;
    keyIdx = KEY_P1_UP;
    if (code[7:0] == SC_P1_UP) begin
      keyIdx = KEY_P1_UP;
    end else if (code[7:0] == SC_P1_DOWN) begin
      keyIdx = KEY_P1_DOWN;
    end else if (code[7:0] == SC_P1_LEFT) begin
      keyIdx = KEY_P1_LEFT;
    end else if (code[7:0] == SC_P1_RIGHT) begin
      keyIdx = KEY_P1_RIGHT;
    end else begin
      case (code)
        SC_P1_FIRE:                   keyIdx = KEY_P1_FIRE;
        SC_P1_BOMB:                   keyIdx = KEY_P1_BOMB;
        SC_P1_START_A, SC_P1_START_B: keyIdx = KEY_P1_START;
        SC_P2_UP:                     keyIdx = KEY_P2_UP;
        SC_P2_DOWN:                   keyIdx = KEY_P2_DOWN;
        SC_P2_LEFT:                   keyIdx = KEY_P2_LEFT;
        SC_P2_RIGHT:                  keyIdx = KEY_P2_RIGHT;
        SC_P2_FIRE:                   keyIdx = KEY_P2_FIRE;
        SC_P2_BOMB:                   keyIdx = KEY_P2_BOMB;
        SC_P2_START_A, SC_P2_START_B: keyIdx = KEY_P2_START;
        SC_COIN0:                     keyIdx = KEY_COIN0;
        SC_COIN1:                     keyIdx = KEY_COIN1;
        default:                      keyHit = 1'b0;
      endcase
    end
  end

  // A key event is a toggle change once primed; the matched latch follows the pressed bit
  always_comb begin
    keys_d = keys_q;
    if (primed_q && (ps2_key[10] != prevTog_q) && keyHit) begin
      keys_d[keyIdx] = ps2_key[9];
    end
  end

  // Toggle tracking; the first edge after reset only captures the toggle so a stale level never decodes
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      primed_q  <= 1'b0;
      prevTog_q <= 1'b0;
      keys_q    <= '0;
    end else begin
      primed_q  <= 1'b1;
      prevTog_q <= ps2_key[10];
      keys_q    <= keys_d;
    end
  end

  // Merge keyboard latches with the pads; pad 1 bomb doubles as a 2P start for single-pad play
  always_comb begin
    up[0]    = keys_q[KEY_P1_UP]    | joystick_0[JOY_UP];
    down[0]  = keys_q[KEY_P1_DOWN]  | joystick_0[JOY_DOWN];
    left[0]  = keys_q[KEY_P1_LEFT]  | joystick_0[JOY_LEFT];
    right[0] = keys_q[KEY_P1_RIGHT] | joystick_0[JOY_RIGHT];
    fire[0]  = keys_q[KEY_P1_FIRE]  | joystick_0[JOY_FIRE];
    bomb[0]  = keys_q[KEY_P1_BOMB]  | joystick_0[JOY_BOMB];
    start[0] = keys_q[KEY_P1_START] | joystick_0[JOY_START];
    up[1]    = keys_q[KEY_P2_UP]    | joystick_1[JOY_UP];
    down[1]  = keys_q[KEY_P2_DOWN]  | joystick_1[JOY_DOWN];
    left[1]  = keys_q[KEY_P2_LEFT]  | joystick_1[JOY_LEFT];
    right[1] = keys_q[KEY_P2_RIGHT] | joystick_1[JOY_RIGHT];
    fire[1]  = keys_q[KEY_P2_FIRE]  | joystick_1[JOY_FIRE];
    bomb[1]  = keys_q[KEY_P2_BOMB]  | joystick_1[JOY_BOMB];
    start[1] = keys_q[KEY_P2_START] | joystick_1[JOY_START] | joystick_0[JOY_BOMB];
    coinReq[0] = keys_q[KEY_COIN0] | joystick_0[JOY_COIN] | start[0] | start[1];
    coinReq[1] = keys_q[KEY_COIN1] | joystick_1[JOY_COIN];
  end

  // Registered active-low buses; contradictory direction pairs cancel each other
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      butUp_q     <= 2'b11;
      butDown_q   <= 2'b11;
      butLeft_q   <= 2'b11;
      butRight_q  <= 2'b11;
      butFire_q   <= 2'b11;
      butBomb_q   <= 2'b11;
      butSelect_q <= 2'b11;
    end else begin
      butUp_q     <= ~(up & ~down);
      butDown_q   <= ~(down & ~up);
      butLeft_q   <= ~(left & ~right);
      butRight_q  <= ~(right & ~left);
      butFire_q   <= ~fire;
      butBomb_q   <= ~bomb;
      butSelect_q <= ~start;
    end
  end

  snapjack_coin_pulser #(
    .COIN_PULSE_CYC(COIN_PULSE_CYC),
    .COIN_GAP_CYC  (COIN_GAP_CYC),
    .CNT_W         (CNT_W)
  ) u_coin0 (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .req    (coinReq[0]),
    .coin_n (but_coin_s[0]),
    .busy   (coin_busy[0])
  );

  snapjack_coin_pulser #(
    .COIN_PULSE_CYC(COIN_PULSE_CYC),
    .COIN_GAP_CYC  (COIN_GAP_CYC),
    .CNT_W         (CNT_W)
  ) u_coin1 (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .req    (coinReq[1]),
    .coin_n (but_coin_s[1]),
    .busy   (coin_busy[1])
  );

  assign but_up_s     = butUp_q;
  assign but_down_s   = butDown_q;
  assign but_left_s   = butLeft_q;
  assign but_right_s  = butRight_q;
  assign but_fire_s   = butFire_q;
  assign but_bomb_s   = butBomb_q;
  assign but_select_s = butSelect_q;

endmodule

// File: tb/tb_snapjack_input_ctrl.sv
// Testbench for snapjack_input_ctrl: directed scenarios followed by random PS/2 and
// pad traffic, every output compared each cycle against a behavioural model.
module tb_snapjack_input_ctrl;

  localparam int PULSE = 4;
  localparam int GAP   = 3;

  // Model function slots per player (slot index doubles as coin slot for F_COIN)
  localparam int F_UP    = 0;
  localparam int F_DOWN  = 1;
  localparam int F_LEFT  = 2;
  localparam int F_RIGHT = 3;
  localparam int F_FIRE  = 4;
  localparam int F_BOMB  = 5;
  localparam int F_START = 6;
  localparam int F_COIN  = 7;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic [1:0]  but_coin_s, but_select_s, but_fire_s, but_bomb_s;
  logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s, coin_busy;

  snapjack_input_ctrl #(
    .COIN_PULSE_CYC(PULSE),
    .COIN_GAP_CYC  (GAP),
    .CNT_W         (20)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET       (RESET),
    .ps2_key     (ps2_key),
    .joystick_0  (joystick_0),
    .joystick_1  (joystick_1),
    .but_coin_s  (but_coin_s),
    .but_select_s(but_select_s),
    .but_fire_s  (but_fire_s),
    .but_bomb_s  (but_bomb_s),
    .but_up_s    (but_up_s),
    .but_down_s  (but_down_s),
    .but_left_s  (but_left_s),
    .but_right_s (but_right_s),
    .coin_busy   (coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model state
  bit   mPrimed, mPrevTog;
  bit   mKey [2][8];
  bit   mPrevReq [2];
  int   mPending [2];
  int   mNextFree [2];
  int   mLastStart [2];
  int   edgeNum;
  logic [1:0] eCoin, eSel, eFire, eBomb, eUp, eDown, eLeft, eRight, eBusy;

  int checkCount = 0;
  int passCount  = 0;
  int coinLow [2];
  logic [8:0] codeList [24];

  // Compare one observed value against the model/hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, actual, expected, edgeNum);
  endtask

  // Scancode table: which player/slot and which function a code drives
  function automatic bit lookupKey(input logic [8:0] code, output int who, output int fn);
    lookupKey = 1'b1;
    who = 0;
    fn  = F_UP;
    case (code[7:0])
      8'h75: fn = F_UP;
      8'h72: fn = F_DOWN;
      8'h6B: fn = F_LEFT;
      8'h74: fn = F_RIGHT;
      default: begin
        if (code[8]) lookupKey = 1'b0;
        else begin
          case (code[7:0])
            8'h14:        fn = F_FIRE;
            8'h29:        fn = F_BOMB;
            8'h05, 8'h16: fn = F_START;
            8'h2E:        fn = F_COIN;
            8'h2D: begin who = 1; fn = F_UP;    end
            8'h2B: begin who = 1; fn = F_DOWN;  end
            8'h23: begin who = 1; fn = F_LEFT;  end
            8'h34: begin who = 1; fn = F_RIGHT; end
            8'h1C: begin who = 1; fn = F_FIRE;  end
            8'h1B: begin who = 1; fn = F_BOMB;  end
            8'h06, 8'h1E: begin who = 1; fn = F_START; end
            8'h36: begin who = 1; fn = F_COIN;  end
            default: lookupKey = 1'b0;
          endcase
        end
      end
    endcase
  endfunction

  task automatic resetModel();
    mPrimed  = 1'b0;
    mPrevTog = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 8; f++) mKey[p][f] = 1'b0;
      mPrevReq[p]   = 1'b0;
      mPending[p]   = 0;
      mNextFree[p]  = 0;
      mLastStart[p] = -1000;
    end
    {eCoin, eSel, eFire, eBomb, eUp, eDown, eLeft, eRight} = {8{2'b11}};
    eBusy = 2'b00;
  endtask

  // Advance the model across one rising edge using the inputs currently driven
  task automatic modelStep();
    bit act [2][8];
    bit req [2];
    bit reqEdge;
    logic [15:0] joy [2];
    int who, fn;
    joy[0] = joystick_0;
    joy[1] = joystick_1;
    for (int p = 0; p < 2; p++) begin
      act[p][F_UP]    = mKey[p][F_UP]    | joy[p][3];
      act[p][F_DOWN]  = mKey[p][F_DOWN]  | joy[p][2];
      act[p][F_LEFT]  = mKey[p][F_LEFT]  | joy[p][1];
      act[p][F_RIGHT] = mKey[p][F_RIGHT] | joy[p][0];
      act[p][F_FIRE]  = mKey[p][F_FIRE]  | joy[p][4];
      act[p][F_BOMB]  = mKey[p][F_BOMB]  | joy[p][5];
      act[p][F_START] = mKey[p][F_START] | joy[p][7];
    end
    act[1][F_START] = act[1][F_START] | joystick_0[5];
    for (int p = 0; p < 2; p++) begin
      eUp[p]    = !(act[p][F_UP] && !act[p][F_DOWN]);
      eDown[p]  = !(act[p][F_DOWN] && !act[p][F_UP]);
      eLeft[p]  = !(act[p][F_LEFT] && !act[p][F_RIGHT]);
      eRight[p] = !(act[p][F_RIGHT] && !act[p][F_LEFT]);
      eFire[p]  = !act[p][F_FIRE];
      eBomb[p]  = !act[p][F_BOMB];
      eSel[p]   = !act[p][F_START];
    end
    req[0] = mKey[0][F_COIN] | joystick_0[6] | act[0][F_START] | act[1][F_START];
    req[1] = mKey[1][F_COIN] | joystick_1[6];
    for (int s = 0; s < 2; s++) begin
      if (edgeNum >= mNextFree[s] && mPending[s] > 0) begin
        mPending[s]--;
        mLastStart[s] = edgeNum;
        mNextFree[s]  = edgeNum + PULSE + GAP + 1;
      end
      reqEdge = req[s] && !mPrevReq[s];
      mPrevReq[s] = req[s];
      if (reqEdge && mPending[s] < 3) mPending[s]++;
      eCoin[s] = !(edgeNum >= mLastStart[s] + 1 && edgeNum <= mLastStart[s] + PULSE);
      eBusy[s] = (mPending[s] > 0) || (edgeNum < mLastStart[s] + PULSE + GAP);
    end
    if (!mPrimed) begin
      mPrimed  = 1'b1;
      mPrevTog = ps2_key[10];
    end else if (ps2_key[10] != mPrevTog) begin
      mPrevTog = ps2_key[10];
      if (lookupKey(ps2_key[8:0], who, fn)) mKey[who][fn] = ps2_key[9];
    end
    edgeNum++;
  endtask

  task automatic checkAll();
    checkOutput("coin",   8'(but_coin_s),   8'(eCoin));
    checkOutput("select", 8'(but_select_s), 8'(eSel));
    checkOutput("fire",   8'(but_fire_s),   8'(eFire));
    checkOutput("bomb",   8'(but_bomb_s),   8'(eBomb));
    checkOutput("up",     8'(but_up_s),     8'(eUp));
    checkOutput("down",   8'(but_down_s),   8'(eDown));
    checkOutput("left",   8'(but_left_s),   8'(eLeft));
    checkOutput("right",  8'(but_right_s),  8'(eRight));
    checkOutput("busy",   8'(coin_busy),    8'(eBusy));
  endtask

  // One clock: model the coming edge, let it happen, then compare on the falling edge
  task automatic applyStimulus();
    modelStep();
    @(posedge clk_sys);
    @(negedge clk_sys);
    checkAll();
    for (int s = 0; s < 2; s++) if (!but_coin_s[s]) coinLow[s]++;
  endtask

  function automatic logic [15:0] randJoy();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(5) != 0) v[6] = 1'b0;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    codeList = '{9'h175, 9'h075, 9'h172, 9'h072, 9'h16B, 9'h06B, 9'h174, 9'h074,
                 9'h014, 9'h114, 9'h029, 9'h005, 9'h016, 9'h02D, 9'h02B, 9'h023,
                 9'h034, 9'h01C, 9'h01B, 9'h006, 9'h01E, 9'h02E, 9'h036, 9'h05A};
    edgeNum    = 0;
    coinLow[0] = 0;
    coinLow[1] = 0;
    RESET      = 1'b1;
    ps2_key    = 11'h400;
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0000;
    resetModel();
    repeat (3) @(negedge clk_sys);
    checkAll();

    // Release with the toggle already high: no phantom key
    RESET = 1'b0;
    repeat (20) applyStimulus();

    // Extended up arrow press, then release
    ps2_key = {~ps2_key[10], 1'b1, 9'h175};
    applyStimulus();
    applyStimulus();
    checkOutput("upKeyPress", 8'(but_up_s), 8'h02);
    ps2_key = {~ps2_key[10], 1'b0, 9'h175};
    repeat (3) applyStimulus();
    checkOutput("upKeyRelease", 8'(but_up_s), 8'h03);

    // Opposing directions cancel, single direction passes through next edge
    joystick_0 = 16'h000C;
    applyStimulus();
    checkOutput("maskUp", 8'(but_up_s), 8'h03);
    checkOutput("maskDown", 8'(but_down_s), 8'h03);
    joystick_0 = 16'h0008;
    applyStimulus();
    checkOutput("upOnly", 8'(but_up_s), 8'h02);
    joystick_0 = 16'h0000;
    repeat (2) applyStimulus();

    // Single coin on slot 0
    coinLow[0] = 0;
    joystick_0 = 16'h0040;
    applyStimulus();
    joystick_0 = 16'h0000;
    applyStimulus();
    checkOutput("coin0NotYet", 8'(but_coin_s), 8'h03);
    applyStimulus();
    checkOutput("coin0Fall", 8'(but_coin_s), 8'h02);
    repeat (18) applyStimulus();
    checkOutput("coin0Len", 8'(coinLow[0]), 8'd4);

    // Five quick edges on slot 1: one immediate plus three saturated credits
    coinLow[0] = 0;
    coinLow[1] = 0;
    for (int i = 0; i < 5; i++) begin
      joystick_1 = 16'h0040;
      applyStimulus();
      joystick_1 = 16'h0000;
      applyStimulus();
    end
    repeat (45) applyStimulus();
    checkOutput("coin1Total", 8'(coinLow[1]), 8'd16);
    checkOutput("coin0Quiet", 8'(coinLow[0]), 8'd0);

    // Reset in the second cycle of a pulse
    joystick_0 = 16'h0040;
    applyStimulus();
    joystick_0 = 16'h0000;
    applyStimulus();
    applyStimulus();
    checkOutput("preRstCoin", 8'(but_coin_s), 8'h02);
    RESET = 1'b1;
    #1;
    checkOutput("rstCoin", 8'(but_coin_s), 8'h03);
    checkOutput("rstBusy", 8'(coin_busy), 8'h00);
    resetModel();
    @(negedge clk_sys);
    checkAll();
    RESET = 1'b0;
    coinLow[0] = 0;
    repeat (20) applyStimulus();
    checkOutput("noPulseAfterRst", 8'(coinLow[0]), 8'd0);

    // Random keyboard and pad traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom_range(1)), codeList[$urandom_range(23)]};
      if ($urandom_range(7) == 0) joystick_0 = randJoy();
      if ($urandom_range(7) == 0) joystick_1 = randJoy();
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/snapjack_input_ctrl.md
Name: snapjack_input_ctrl

Overview:
- Input conditioning stage between hps_io and the ladybug core in the Snap Jack emu top.
- Decodes PS/2 key events and merges them with both MiSTer joysticks.
- Masks opposing joystick directions.
- Converts coin requests into fixed-width, spaced coin-mech pulses.
- Drives the core's active-low 2-bit but_*_s buses from registers.

Parameters:
- COIN_PULSE_CYC, 400000: clk_sys cycles the coin line is held asserted per credit.
- COIN_GAP_CYC, 400000: clk_sys cycles the coin line is held deasserted after each pulse.
- CNT_W, 20: width of the coin timing counter; must hold max(COIN_PULSE_CYC, COIN_GAP_CYC).

Ports:
- clk_sys  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] toggles once per event, [9] pressed, [8:0] extended flag + scancode.
- joystick_0  in  16  player 1 pad: [0]R [1]L [2]D [3]U [4]fire [5]bomb [6]coin [7]start.
- joystick_1  in  16  player 2 pad, same bit map as joystick_0.
- but_coin_s  out  2  active-low coin, slot [0] and slot [1].
- but_select_s  out  2  active-low start; [0] = 1P, [1] = 2P.
- but_fire_s, but_bomb_s  out  2 each  active-low; [0] = P1, [1] = P2.
- but_up_s, but_down_s, but_left_s, but_right_s  out  2 each  active-low directions; [0] = P1, [1] = P2.
- coin_busy  out  2  high while a slot's pulser is not IDLE or still has credits pending.

Behaviour:
- Reset:
  - All key latches are cleared and both coin FSMs return to IDLE with credits = 0.
  - All but_* outputs = 2'b11 (released); coin_busy = 0.
  - A primed flag is cleared.
- PS/2 event detect:
  - prev_tog is a register holding ps2_key[10].
  - On the first edge after reset, prev_tog is captured, primed is set, and no event is decoded. A stale toggle at reset therefore never registers as a keypress.
  - After priming, an event is ps2_key[10] != prev_tog. On that edge the matched key latch is set to ps2_key[9].
- Key map (bit 8 = extended flag, X = don't care):
  - P1: X75 up, X72 down, X6B left, X74 right, 014 fire, 029 bomb, 005 / 016 start1.
  - P2: 02D up, 02B down, 023 left, 034 right, 01C fire, 01B bomb, 006 / 01E start2.
  - Coins: 02E coin slot 0, 036 coin slot 1.
  - Unmapped codes are ignored.
- Merge:
  - Each P1 signal = its key latch OR joystick_0 bit; each P2 signal = its key latch OR joystick_1 bit.
  - start2 additionally ORs joystick_0[5] (single-pad 2P start). Bomb P1 still uses joystick_0[5].
- Opposing-direction mask, per player:
  - If up and down are both active, neither is output.
  - If left and right are both active, neither is output.
- Coin request:
  - slot0 request = key 02E | joystick_0[6] | start1 | start2.
  - slot1 request = key 036 | joystick_1[6].
  - Only the rising edge of a request counts. Each slot registers its own previous request level.
- Coin FSM, one per slot:
  - IDLE: if credits > 0, decrement credits, load cnt = COIN_PULSE_CYC-1, go to PULSE.
  - PULSE: coin asserted. If cnt = 0, load cnt = COIN_GAP_CYC-1 and go to GAP; otherwise decrement cnt.
  - GAP: coin deasserted. If cnt = 0, go to IDLE; otherwise decrement cnt.
  - Pulse length is exactly COIN_PULSE_CYC cycles. Minimum spacing between pulses is COIN_GAP_CYC + 1 cycles (the extra cycle is spent in IDLE).
  - credits is 2 bits and saturates at 3; further edges are dropped.
  - An edge arriving on the same cycle as an IDLE decrement nets to an unchanged credit count, and the pulse still starts.
- Latency:
  - Joystick change before edge N appears on the outputs after edge N.
  - PS/2 toggle before edge N appears after edge N+1.
  - Coin request edge before edge N: the slot enters PULSE after edge N+1, and but_coin_s falls after edge N+2.
- RESET mid-pulse aborts the pulse immediately (async); but_coin_s returns to 1.

Decomposition:
- snapjack_input_pkg holds:
  - scancode localparams;
  - joystick bit-index localparams;
  - the coin_state_t enum {IDLE, PULSE, GAP}.
- One sub-module, snapjack_coin_pulser: per-slot edge detect, credit counter and FSM, instantiated twice.
  - Ports: clk_sys, RESET, req, coin_n, busy.
  - Parameters: COIN_PULSE_CYC, COIN_GAP_CYC, CNT_W.

Test Plan (bench uses COIN_PULSE_CYC=4, COIN_GAP_CYC=3):
- Release RESET with ps2_key[10] = 1 and no further toggle -> all outputs stay 2'b11 for 20 cycles; no phantom key.
- ps2_key toggle with {pressed, code} = {1, 9'h175} -> but_up_s = 2'b10 two edges later. Toggle again with {0, 9'h175} -> back to 2'b11.
- joystick_0 = 16'h000C (up + down) -> but_up_s = but_down_s = 2'b11. Then joystick_0 = 16'h0008 -> but_up_s = 2'b10 after one edge.
- One-cycle pulse on joystick_0[6] -> but_coin_s[0] = 0 for exactly 4 cycles starting 3 edges after the request, then 1. coin_busy[0] drops after the 3-cycle gap plus the IDLE cycle.
- Five rising edges on joystick_1[6] within one pulse window -> exactly 4 pulses on but_coin_s[1] (1 immediate + 3 saturated credits), each separated by 4 high cycles. but_coin_s[0] stays 1 throughout.
- Assert RESET during the 2nd cycle of PULSE -> but_coin_s = 2'b11 and coin_busy = 0 immediately. After release, no pulse occurs without a new request edge.
